mcs4_fetch: RTL and testbench
=============================

MCS4_FETCH -- requirements
Module: mcs4_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port cycle, output, 3 bits: current instruction sub-cycle, encoded A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
REQ-004 SHALL have port sync, output, 1 bit: high while cycle==X3.
REQ-005 SHALL have port data_o, output, 4 bits: address nibble driven to the ROM bus.
REQ-006 SHALL have port data_oe, output, 1 bit: high while data_o is valid.
REQ-007 SHALL have port data_i, input, 4 bits: ROM nibble, sampled in M1 and M2.
REQ-008 SHALL have port pc, output, 12 bits: address of the byte being fetched.
REQ-009 SHALL have port pc_load, input, 1 bit: jump request from execute.
REQ-010 SHALL have port pc_load_addr, input, 12 bits: jump target.
REQ-011 SHALL have port instr_valid, output, 1 bit: one-cycle pulse marking a complete instruction.
REQ-012 SHALL have port instr, output, 8 bits: first byte of the instruction, {OPR, OPA}.
REQ-013 SHALL have port instr2, output, 8 bits: second byte; 0x00 for one-word instructions.
REQ-014 SHALL have port two_word, output, 1 bit: qualifies instr2.

Function
REQ-015 cycle SHALL advance by one every clock, A1->...->X3->A1, with no idle states.
REQ-016 In A1, A2 and A3, data_o SHALL equal pc[3:0], pc[7:4] and pc[11:8] respectively, with data_oe=1; in all other cycles data_oe=0 and data_o=0.
REQ-017 The block SHALL latch data_i as the high nibble of the fetched byte at the end of M1, and as the low nibble at the end of M2.
REQ-018 pc SHALL increment by 1 at the end of X1, wrapping 0xFFF->0x000.
REQ-019 A first byte SHALL be classified two-word when any of the following holds:
- OPR is 0001 (JCN);
- OPR is 0100 (JUN);
- OPR is 0101 (JMS);
- OPR is 0111 (ISZ);
- OPR is 0010 and OPA[0]=0 (FIM).
FIN and all other opcodes SHALL be one-word.
REQ-020 For a one-word byte, instr_valid SHALL pulse during the X1 that follows its M2, with instr set to the byte, instr2=0x00 and two_word=0.
REQ-021 For a two-word byte, the block SHALL set an internal pending flag and produce no pulse.
- The next instruction cycle SHALL fetch the second byte.
- instr_valid SHALL pulse in that cycle's X1, with instr set to the first byte, instr2 to the second byte, and two_word=1.
- The pending flag SHALL then clear.
REQ-022 A second byte SHALL never be classified, whatever its value.
REQ-023 instr, instr2 and two_word SHALL hold their values until the next instr_valid pulse.
REQ-024 pc_load SHALL be sampled only while cycle==X3; when sampled high, pc SHALL take pc_load_addr, so that the next A1 drives the target. pc_load outside X3 SHALL be ignored.
REQ-025 A pc_load sampled high while the pending flag is set SHALL clear the pending flag, discarding the partial instruction (no pulse).
REQ-026 pc_load_addr=0xFFF SHALL be legal; the increment after that fetch SHALL wrap pc to 0x000.

Reset
REQ-027 While rst is high, the block SHALL drive the following values:
- cycle=A1, sync=0;
- pc=0x000;
- data_oe=0, data_o=0;
- instr_valid=0, instr=0x00, instr2=0x00, two_word=0;
- pending flag cleared.
REQ-028 A reset asserted mid-instruction SHALL abandon the fetch; the first clock after rst falls SHALL be A1, driving nibble 0x0 of pc=0x000.

Configuration
REQ-029 With macro MCS4_FETCH_STALL_EN defined, the block SHALL add a 1-bit input named stall.
- When stall is high during X3, cycle SHALL remain X3 and sync SHALL remain high.
- While held, pc_load SHALL be sampled every held cycle, and the last sampled value SHALL win.
- cycle SHALL advance to A1 on the first clock with stall low.
REQ-030 Without MCS4_FETCH_STALL_EN, the stall port SHALL be absent and X3 SHALL always last exactly one clock.

Verification
REQ-031 Reset, then ROM returns 0xD5 (LDM) at 0x000 -> data_o sequence 0,0,0 in A1–A3; instr_valid in X1 with instr=0xD5 and two_word=0; pc=0x001.
REQ-032 ROM returns 0x40 at 0x000 and 0x7B at 0x001 (JUN 0x07B) -> no pulse in the first cycle; a pulse in the second cycle's X1 with instr=0x40, instr2=0x7B and two_word=1; pc=0x002.
REQ-033 Assert pc_load with pc_load_addr=0x3A5 during X3 -> the next A1/A2/A3 drive 5, A, 3; pc_load with pc_load_addr=0x111 asserted during X1 has no effect.
REQ-034 Jump to 0xFFF, ROM returns 0x20 (FIM) at 0xFFF and 0x99 at 0x000 -> second fetch address is 0x000; instr=0x20 and instr2=0x99; a 0x21 (SRC) byte is classified one-word.
REQ-035 Assert rst during M2 of a two-word fetch -> outputs take their reset values; after release, fetch restarts at 0x000 and no stale pulse occurs.
REQ-036 With MCS4_FETCH_STALL_EN, hold stall for 3 clocks at X3 -> sync stays high for 4 clocks; pc_load with pc_load_addr=0x200 on the last held clock is taken.

Source files
------------

// File: rtl/mcs4_fetch.sv
// rtl/mcs4_fetch.sv - MCS-4 style eight-phase instruction fetch sequencer
// Optional X3 stall input enabled by macro MCS4_FETCH_STALL_EN.
module mcs4_fetch (
    input  logic        clk,
    input  logic        rst,
    output logic [2:0]  cycle,
    output logic        sync,
    output logic [3:0]  data_o,
    output logic        data_oe,
    input  logic [3:0]  data_i,
    output logic [11:0] pc,
    input  logic        pc_load,
    input  logic [11:0] pc_load_addr,
`ifdef MCS4_FETCH_STALL_EN
    input  logic        stall,
`endif
    output logic        instr_valid,
    output logic [7:0]  instr,
    output logic [7:0]  instr2,
    output logic        two_word
);

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } cycle_t;

    cycle_t      state;
    logic        pending;
    logic [3:0]  opr_lat;
    logic [7:0]  first_byte;
    logic [7:0]  fetched;
    logic        hold;

`ifdef MCS4_FETCH_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // Low nibble is taken straight off the bus on the M2 edge.
    assign fetched = {opr_lat, data_i};

    function automatic logic is_two_word(input logic [7:0] b);
        case (b[7:4])
            4'h1, 4'h4, 4'h5, 4'h7: is_two_word = 1'b1;
            4'h2:                   is_two_word = ~b[0];
            default:                is_two_word = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= A1;
            pc          <= 12'h000;
            pending     <= 1'b0;
            opr_lat     <= 4'h0;
            first_byte  <= 8'h00;
            instr_valid <= 1'b0;
            instr       <= 8'h00;
            instr2      <= 8'h00;
            two_word    <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                A1: state <= A2;
                A2: state <= A3;
                A3: state <= M1;
                M1: begin
                    opr_lat <= data_i;
                    state   <= M2;
                end
                M2: begin
                    state <= X1;
                    if (pending) begin
                        instr_valid <= 1'b1;
                        instr       <= first_byte;
                        instr2      <= fetched;
                        two_word    <= 1'b1;
                        pending     <= 1'b0;
                    end else if (is_two_word(fetched)) begin
                        pending    <= 1'b1;
                        first_byte <= fetched;
                    end else begin
                        instr_valid <= 1'b1;
                        instr       <= fetched;
                        instr2      <= 8'h00;
                        two_word    <= 1'b0;
                    end
                end
                X1: begin
                    pc    <= pc + 12'd1;
                    state <= X2;
                end
                X2: state <= X3;
                X3: begin
                    // A jump abandons any half-fetched two-word instruction.
                    if (pc_load) begin
                        pc      <= pc_load_addr;
                        pending <= 1'b0;
                    end
                    if (!hold) begin
                        state <= A1;
                    end
                end
                default: state <= A1;
            endcase
        end
    end

    assign cycle = state;
    assign sync  = (state == X3);

    // Bus is released while reset is held even though the state reads A1.
    always_comb begin
        data_oe = 1'b0;
        data_o  = 4'h0;
        if (!rst) begin
            case (state)
                A1: begin
                    data_oe = 1'b1;
                    data_o  = pc[3:0];
                end
                A2: begin
                    data_oe = 1'b1;
                    data_o  = pc[7:4];
                end
                A3: begin
                    data_oe = 1'b1;
                    data_o  = pc[11:8];
                end
                default: begin
                    data_oe = 1'b0;
                    data_o  = 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcs4_fetch.sv
// tb/tb_mcs4_fetch.sv - randomized self-checking bench for mcs4_fetch
// Behavioural ROM plus instruction-level reference model.
module tb_mcs4_fetch;

    logic        clk;
    logic        rst;
    logic [2:0]  cycle;
    logic        sync;
    logic [3:0]  data_o;
    logic        data_oe;
    logic [3:0]  data_i;
    logic [11:0] pc;
    logic        pc_load;
    logic [11:0] pc_load_addr;
    logic        instr_valid;
    logic [7:0]  instr;
    logic [7:0]  instr2;
    logic        two_word;
`ifdef MCS4_FETCH_STALL_EN
    logic        stall;
`endif

    mcs4_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .cycle        (cycle),
        .sync         (sync),
        .data_o       (data_o),
        .data_oe      (data_oe),
        .data_i       (data_i),
        .pc           (pc),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
`ifdef MCS4_FETCH_STALL_EN
        .stall        (stall),
`endif
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr2       (instr2),
        .two_word     (two_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  rom [4096];
    logic [11:0] m_pc;
    logic        m_pend;
    logic [7:0]  m_first;
    logic [7:0]  m_instr;
    logic [7:0]  m_instr2;
    logic        m_tw;
    logic [11:0] f_addr;
    logic [11:0] cap_addr;
    int          n_cmp;
    int          n_bad;

    function automatic logic two_word_op(input logic [7:0] b);
        logic [3:0] opr;
        opr = b[7:4];
        return (opr == 4'd1) || (opr == 4'd4) || (opr == 4'd5) || (opr == 4'd7) ||
               (opr == 4'd2 && b[0] == 1'b0);
    endfunction

    task automatic model_reset();
        m_pc = 12'h000; m_pend = 1'b0; m_first = 8'h00;
        m_instr = 8'h00; m_instr2 = 8'h00; m_tw = 1'b0;
    endtask

    // One clock of an instruction cycle: drive, advance the model, compare, clock.
    task automatic clk_step(input int k, input logic ld, input logic [11:0] la);
        logic [7:0] b;
        logic       exp_v;
        logic [3:0] exp_d;
        pc_load = ld;
        pc_load_addr = la;
        if (k == 3)      data_i = rom[cap_addr][7:4];
        else if (k == 4) data_i = rom[cap_addr][3:0];
        else             data_i = 4'($urandom);
        if (k == 0) f_addr = m_pc;
        exp_v = 1'b0;
        if (k == 5) begin
            b = rom[f_addr];
            if (m_pend) begin
                exp_v = 1'b1; m_instr = m_first; m_instr2 = b; m_tw = 1'b1; m_pend = 1'b0;
            end else if (two_word_op(b)) begin
                m_pend = 1'b1; m_first = b;
            end else begin
                exp_v = 1'b1; m_instr = b; m_instr2 = 8'h00; m_tw = 1'b0;
            end
        end
        if (k == 6) m_pc = m_pc + 12'd1;
        exp_d = (k < 3) ? f_addr[k*4 +: 4] : 4'h0;
        #1;
        n_cmp++; if (cycle !== 3'(k)) begin n_bad++; $display("FAIL cycle: got %0d want %0d", cycle, k); end
        n_cmp++; if (sync !== (k == 7)) begin n_bad++; $display("FAIL sync k=%0d: got %b want %b", k, sync, (k == 7)); end
        n_cmp++; if (data_oe !== (k < 3)) begin n_bad++; $display("FAIL data_oe k=%0d: got %b want %b", k, data_oe, (k < 3)); end
        n_cmp++; if (data_o !== exp_d) begin n_bad++; $display("FAIL data_o k=%0d: got %h want %h", k, data_o, exp_d); end
        n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL pc k=%0d: got %h want %h", k, pc, m_pc); end
        n_cmp++; if (instr_valid !== exp_v) begin n_bad++; $display("FAIL instr_valid k=%0d: got %b want %b", k, instr_valid, exp_v); end
        n_cmp++; if (instr !== m_instr) begin n_bad++; $display("FAIL instr k=%0d: got %h want %h", k, instr, m_instr); end
        n_cmp++; if (instr2 !== m_instr2) begin n_bad++; $display("FAIL instr2 k=%0d: got %h want %h", k, instr2, m_instr2); end
        n_cmp++; if (two_word !== m_tw) begin n_bad++; $display("FAIL two_word k=%0d: got %b want %b", k, two_word, m_tw); end
        if (k < 3) cap_addr[k*4 +: 4] = data_o;
        @(posedge clk);
        if (k == 7 && ld) begin m_pc = la; m_pend = 1'b0; end
        @(negedge clk);
    endtask

    task automatic do_instr(input logic ld3, input logic [11:0] la3, input logic junk);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) clk_step(k, ld3, la3);
            else        clk_step(k, junk ? 1'($urandom) : 1'b0, 12'($urandom));
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; pc_load = 1'b1; pc_load_addr = 12'($urandom); data_i = 4'($urandom);
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        n_cmp++; if (cycle !== 3'd0) begin n_bad++; $display("FAIL rst_cycle: got %0d want 0", cycle); end
        n_cmp++; if (sync !== 1'b0) begin n_bad++; $display("FAIL rst_sync: got %b want 0", sync); end
        n_cmp++; if (pc !== 12'h000) begin n_bad++; $display("FAIL rst_pc: got %h want 000", pc); end
        n_cmp++; if (data_oe !== 1'b0 || data_o !== 4'h0) begin n_bad++; $display("FAIL rst_bus: got oe=%b d=%h want 0/0", data_oe, data_o); end
        n_cmp++; if (instr_valid !== 1'b0 || two_word !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got v=%b tw=%b want 0/0", instr_valid, two_word); end
        n_cmp++; if (instr !== 8'h00 || instr2 !== 8'h00) begin n_bad++; $display("FAIL rst_instr: got %h/%h want 00/00", instr, instr2); end
        rst = 1'b0; pc_load = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_one_word();
        apply_reset();
        rom[0] = 8'hD5;
        do_instr(1'b0, 12'h000, 1'b0);
        n_cmp++; if (cap_addr !== 12'h000) begin n_bad++; $display("FAIL ow_addr: got %h want 000", cap_addr); end
        n_cmp++; if (instr !== 8'hD5 || two_word !== 1'b0) begin n_bad++; $display("FAIL ow_instr: got %h tw=%b want d5 tw=0", instr, two_word); end
        n_cmp++; if (pc !== 12'h001) begin n_bad++; $display("FAIL ow_pc: got %h want 001", pc); end
    endtask

    task automatic test_two_word();
        apply_reset();
        rom[0] = 8'h40; rom[1] = 8'h7B;
        do_instr(1'b0, 12'h000, 1'b0);
        do_instr(1'b0, 12'h000, 1'b0);
        n_cmp++; if (instr !== 8'h40 || instr2 !== 8'h7B || two_word !== 1'b1) begin
            n_bad++; $display("FAIL tw_instr: got %h %h tw=%b want 40 7b tw=1", instr, instr2, two_word); end
        n_cmp++; if (pc !== 12'h002) begin n_bad++; $display("FAIL tw_pc: got %h want 002", pc); end
    endtask

    task automatic test_jump();
        apply_reset();
        rom[0] = 8'hD5; rom[12'h3A5] = 8'hD5;
        for (int k = 0; k < 8; k++) begin
            if (k == 5)      clk_step(k, 1'b1, 12'h111);
            else if (k == 7) clk_step(k, 1'b1, 12'h3A5);
            else             clk_step(k, 1'b0, 12'h000);
        end
        do_instr(1'b0, 12'h000, 1'b0);
        n_cmp++; if (cap_addr !== 12'h3A5) begin n_bad++; $display("FAIL jump_addr: got %h want 3a5", cap_addr); end
        n_cmp++; if (pc !== 12'h3A6) begin n_bad++; $display("FAIL jump_pc: got %h want 3a6", pc); end
    endtask

    task automatic test_wrap();
        apply_reset();
        rom[0] = 8'hD5;
        do_instr(1'b1, 12'hFFF, 1'b0);
        rom[12'hFFF] = 8'h20; rom[0] = 8'h99; rom[1] = 8'h21;
        do_instr(1'b0, 12'h000, 1'b0);
        n_cmp++; if (pc !== 12'h000) begin n_bad++; $display("FAIL wrap_pc: got %h want 000", pc); end
        do_instr(1'b0, 12'h000, 1'b0);
        n_cmp++; if (cap_addr !== 12'h000) begin n_bad++; $display("FAIL wrap_addr: got %h want 000", cap_addr); end
        n_cmp++; if (instr !== 8'h20 || instr2 !== 8'h99 || two_word !== 1'b1) begin
            n_bad++; $display("FAIL wrap_fim: got %h %h tw=%b want 20 99 tw=1", instr, instr2, two_word); end
        do_instr(1'b0, 12'h000, 1'b0);
        n_cmp++; if (instr !== 8'h21 || instr2 !== 8'h00 || two_word !== 1'b0) begin
            n_bad++; $display("FAIL src_one: got %h %h tw=%b want 21 00 tw=0", instr, instr2, two_word); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rom[0] = 8'h40; rom[1] = 8'h7B;
        do_instr(1'b0, 12'h000, 1'b0);
        for (int k = 0; k < 4; k++) clk_step(k, 1'b0, 12'h000);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk); #1;
            n_cmp++; if (cycle !== 3'd0 || pc !== 12'h000 || data_oe !== 1'b0) begin
                n_bad++; $display("FAIL mid_rst: got cyc=%0d pc=%h oe=%b want 0/000/0", cycle, pc, data_oe); end
            n_cmp++; if (instr_valid !== 1'b0 || instr !== 8'h00 || two_word !== 1'b0) begin
                n_bad++; $display("FAIL mid_rst_out: got v=%b i=%h tw=%b want 0/00/0", instr_valid, instr, two_word); end
        end
        rst = 1'b0;
        model_reset();
        rom[0] = 8'hD5;
        do_instr(1'b0, 12'h000, 1'b0);
        n_cmp++; if (instr !== 8'hD5 || two_word !== 1'b0 || cap_addr !== 12'h000) begin
            n_bad++; $display("FAIL mid_restart: got %h tw=%b addr=%h want d5 tw=0 addr=000", instr, two_word, cap_addr); end
    endtask

`ifdef MCS4_FETCH_STALL_EN
    task automatic test_stall();
        int sync_cnt;
        apply_reset();
        rom[0] = 8'hD5; rom[12'h200] = 8'hD5;
        sync_cnt = 0;
        for (int k = 0; k < 7; k++) clk_step(k, 1'b0, 12'h000);
        stall = 1'b1;
        for (int h = 0; h < 3; h++) begin
            pc_load = (h != 1);
            pc_load_addr = (h == 0) ? 12'h555 : 12'h200;
            #1;
            n_cmp++; if (cycle !== 3'd7) begin n_bad++; $display("FAIL stall_cycle h=%0d: got %0d want 7", h, cycle); end
            if (sync === 1'b1) sync_cnt++;
            @(posedge clk);
            if (pc_load) m_pc = pc_load_addr;
            @(negedge clk);
        end
        stall = 1'b0;
        #1; if (sync === 1'b1) sync_cnt++;
        clk_step(7, 1'b0, 12'h000);
        n_cmp++; if (sync_cnt !== 4) begin n_bad++; $display("FAIL stall_sync: got %0d want 4", sync_cnt); end
        do_instr(1'b0, 12'h000, 1'b0);
        n_cmp++; if (cap_addr !== 12'h200) begin n_bad++; $display("FAIL stall_load: got %h want 200", cap_addr); end
    endtask
`endif

    task automatic test_random();
        logic        ld;
        logic [11:0] la;
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        apply_reset();
        for (int i = 0; i < 150; i++) begin
            ld = ($urandom_range(5) == 0);
            la = ($urandom_range(3) == 0) ? 12'hFFF : 12'($urandom);
            do_instr(ld, la, 1'b1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; pc_load = 1'b0; pc_load_addr = 12'h000; data_i = 4'h0;
        cap_addr = 12'h000; f_addr = 12'h000;
`ifdef MCS4_FETCH_STALL_EN
        stall = 1'b0;
`endif
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        model_reset();
        @(negedge clk);
        test_reset();
        test_one_word();
        test_two_word();
        test_jump();
        test_wrap();
        test_reset_mid();
`ifdef MCS4_FETCH_STALL_EN
        test_stall();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
